// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default adder geometry, add/sub mode
// encoding and an elaboration-time geometry check.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_SLICE = 8;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // True when the word splits into a whole number of look-ahead slices.
    function automatic bit width_ok(input int unsigned width, input int unsigned slice);
        return (slice != 0) && (width != 0) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
interface pipelined_cla_addsub_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    // The arithmetic unit itself.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-look-ahead slice. Every internal carry is a
// flat sum of generate/propagate products, so there is no ripple path.
module cla_slice #(
    parameter int unsigned SLICE = alu_pkg::DEFAULT_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             acc;
    logic             run;

    // Expand c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin for every bit.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        acc  = 1'b0;
        run  = 1'b0;
        for (int unsigned i = 0; i < SLICE; i++) begin
            acc = g[i];
            run = p[i];
            for (int unsigned k = 0; k < i; k++) begin
                acc = acc | (run & g[i-1-k]);
                run = run & p[i-1-k];
            end
            c[i+1] = acc | (run & cin);
        end
        sum   = p ^ c[SLICE-1:0];
        cout  = c[SLICE];
        c_msb = c[SLICE-1];
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined WIDTH-bit add/subtract unit: one look-ahead slice per stage with
// the inter-slice carry registered, valid/ready handshake with backpressure.
module pipelined_cla_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SLICE = DEFAULT_SLICE
) (
    input logic                   clock,
    input logic                   reset_n,
    pipelined_cla_addsub_if.slave bus
);

    localparam int unsigned STAGES = WIDTH / SLICE;

    if (!width_ok(WIDTH, SLICE)) begin : g_bad_geometry
        $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of SLICE");
    end

    mode_e mode;
    logic  advance;

    // Stage registers. Operand words travel whole so slice k meets stage k;
    // sum words accumulate finished slices so the result leaves together.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic              ovf_q;

    // Inputs seen by each stage this cycle.
    logic [WIDTH-1:0]  st_a     [STAGES];
    logic [WIDTH-1:0]  st_b     [STAGES];
    logic [WIDTH-1:0]  st_s     [STAGES];
    logic [WIDTH-1:0]  st_snext [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;

    logic [STAGES-1:0][SLICE-1:0] sl_sum;
    logic [STAGES-1:0]            sl_cout;
    logic                         sl_cmsb [STAGES];

    // The whole pipe moves only when the output slot is free or draining.
    always_comb begin
        advance      = !valid_q[STAGES-1] || bus.out_ready;
        bus.in_ready = advance;
    end

    // Stage 0 takes effective operands from the bus; later stages take the
    // previous stage's registers.
    always_comb begin
        mode    = mode_e'(bus.sub);
        st_a[0] = bus.a;
        st_b[0] = (mode == MODE_SUB) ? ~bus.b : bus.b;
        st_c[0] = (mode == MODE_SUB) ? 1'b1 : bus.cin;
        st_v[0] = bus.in_valid;
        st_s[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_c[k] = carry_q[k-1];
            st_v[k] = valid_q[k-1];
            st_s[k] = sum_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a     (st_a[k][k*SLICE +: SLICE]),
            .b     (st_b[k][k*SLICE +: SLICE]),
            .cin   (st_c[k]),
            .sum   (sl_sum[k]),
            .cout  (sl_cout[k]),
            .c_msb (sl_cmsb[k])
        );
    end

    // Merge each stage's freshly computed slice into its partial sum word.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            st_snext[k]                    = st_s[k];
            st_snext[k][k*SLICE +: SLICE] = sl_sum[k];
        end
    end

    // Valid bits: cleared by reset, otherwise shifted on advance (bubbles kept).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= st_v;
        end
    end

    // Datapath registers: no reset needed, invalid slots are masked at the output.
    always_ff @(posedge clock) begin
        if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= st_a[k];
                b_q[k]   <= st_b[k];
                sum_q[k] <= st_snext[k];
            end
            carry_q <= sl_cout;
            ovf_q   <= sl_cmsb[STAGES-1] ^ sl_cout[STAGES-1];
        end
    end

    // Result port reads zero whenever the output slot is empty.
    always_comb begin
        bus.out_valid = valid_q[STAGES-1];
        bus.sum       = valid_q[STAGES-1] ? sum_q[STAGES-1] : '0;
        bus.cout      = valid_q[STAGES-1] ? carry_q[STAGES-1] : 1'b0;
        bus.overflow  = valid_q[STAGES-1] ? ovf_q : 1'b0;
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (WIDTH=32, SLICE=8).
module tb_pipelined_cla_addsub;

    localparam int STAGES = 4;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   n_out;
    res_t exp_q [$];
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    pipelined_cla_addsub_if #(.WIDTH(32)) bus ();

    pipelined_cla_addsub #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mcin, input logic msub);
        res_t        r;
        logic [31:0] be;
        logic [32:0] t;
        be     = msub ? ~mb : mb;
        t      = {1'b0, ma} + {1'b0, be} + {32'd0, (msub ? 1'b1 : mcin)};
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (ma[31] == be[31]) && (t[31] != ma[31]);
        return r;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_result", 64'(bus.out_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("sb_sum", 64'(bus.sum), 64'(e.sum));
                        check_eq("sb_cout", 64'(bus.cout), 64'(e.cout));
                        check_eq("sb_ovf", 64'(bus.overflow), 64'(e.ovf));
                        n_out++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle_junk();
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.cin      = 1'($urandom_range(0, 1));
        bus.sub      = 1'($urandom_range(0, 1));
    endtask

    // Drive one op and wait (bounded) for the edge that accepts it.
    task automatic push_op(input logic [31:0] ta, input logic [31:0] tb, input logic tcin, input logic tsub);
        bit acc;
        int g;
        acc = 1'b0;
        g   = 0;
        bus.a = ta; bus.b = tb; bus.cin = tcin; bus.sub = tsub; bus.in_valid = 1'b1;
        while (!acc && g < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            g++;
        end
        check_eq("accept", 64'(acc), 64'd1);
        idle_junk();
    endtask

    // Single op on an empty pipe: latency, constant expectations, one-cycle pulse.
    task automatic run_single(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                              input logic tcin, input logic tsub,
                              input logic [31:0] esum, input logic ecout, input logic eovf);
        int lat;
        bit seen;
        bus.a = ta; bus.b = tb; bus.cin = tcin; bus.sub = tsub; bus.in_valid = 1'b1;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        idle_junk();
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = bus.out_valid;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(STAGES));
        check_eq({tag, "_sum"}, 64'(bus.sum), 64'(esum));
        check_eq({tag, "_cout"}, 64'(bus.cout), 64'(ecout));
        check_eq({tag, "_ovf"}, 64'(bus.overflow), 64'(eovf));
        @(negedge clk);
        check_eq({tag, "_pulse"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        int m;
        logic exp_v;
        n_checks = 0; n_fail = 0; n_out = 0;
        reset_n = 1'b0;
        bus.out_ready = 1'b1;
        idle_junk();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_sum", 64'(bus.sum), 64'd0);
        check_eq("rst_cout", 64'(bus.cout), 64'd0);
        check_eq("rst_ovf", 64'(bus.overflow), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Directed corner cases.
        run_single("add_ff_1",    32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_single("add_carry",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_single("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_single("sub_borrow",  32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_single("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Back-to-back stream with a 3-cycle output stall.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) push_op(32'(i), 32'(i * 3), 1'b0, 1'b0);
            end
            begin
                int g;
                g = 0;
                while (!bus.out_valid && g < 50) begin
                    @(posedge clk); #1;
                    g++;
                end
                check_eq("stall_start", 64'(bus.out_valid), 64'd1);
                bus.out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    check_eq("stall_out_valid", 64'(bus.out_valid), 64'd1);
                    if (exp_q.size() != 0) begin
                        check_eq("stall_sum", 64'(bus.sum), 64'(exp_q[0].sum));
                        check_eq("stall_cout", 64'(bus.cout), 64'(exp_q[0].cout));
                    end
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("stream");
        check_eq("stream_count", 64'(n_out - base), 64'd8);

        // Bubble pattern must reappear unchanged STAGES edges later.
        for (int j = 0; j <= 10; j++) begin
            idle_junk();
            bus.in_valid = (j < 5) ? pat[j] : 1'b0;
            @(negedge clk);
            if (j >= 1) begin
                m     = j - 1;
                exp_v = (m >= STAGES - 1 && m < STAGES - 1 + 5) ? pat[m - (STAGES - 1)] : 1'b0;
                check_eq($sformatf("bubble_ov%0d", m), 64'(bus.out_valid), 64'(exp_v));
            end
            @(posedge clk); #1;
        end
        idle_junk();
        drain("bubble");

        // Random ops under random backpressure.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 24; i++)
                    push_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (60) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain("random");
        check_eq("random_count", 64'(n_out - base), 64'd24);

        // Reset with three ops in flight flushes them all.
        for (int i = 0; i < 3; i++) push_op($urandom, $urandom, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("flush_sum", 64'(bus.sum), 64'd0);
        check_eq("flush_cout", 64'(bus.cout), 64'd0);
        check_eq("flush_ovf", 64'(bus.overflow), 64'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq($sformatf("flush_stale%0d", c), 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk); #1;
        run_single("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h0123_4567, 1'b1, 1'b0);

        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
